// File: rtl/adder_bist_ctrl.sv
// Exhaustive operand-sweep BIST controller for a WIDTH-bit adder.
// Drives A/B, waits SETTLE+1 cycles per pair, checks {carry,sum} against A+B.
module adder_bist_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] RELOAD = SW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    state_t           state, state_n;
    logic [SW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] a_n, b_n, fa_n, fb_n;
    logic [CNT_W-1:0] err_n;
    logic             seen, seen_n;
    logic             pass_n;
    logic [WIDTH:0]   golden;
    logic             mismatch;
    logic             last;

    assign golden   = {1'b0, A} + {1'b0, B};
    assign mismatch = ({carry, sum} != golden);
    assign last     = (&A) & (&B);

    assign busy = (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            A         <= '0;
            B         <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            seen      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            A         <= a_n;
            B         <= b_n;
            err_count <= err_n;
            fail_a    <= fa_n;
            fail_b    <= fb_n;
            seen      <= seen_n;
            pass      <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = A;
        b_n     = B;
        err_n   = err_count;
        fa_n    = fail_a;
        fb_n    = fail_b;
        seen_n  = seen;
        pass_n  = pass;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_n     = '0;
                    b_n     = '0;
                    err_n   = '0;
                    fa_n    = '0;
                    fb_n    = '0;
                    seen_n  = 1'b0;
                    pass_n  = 1'b0;
                    cnt_n   = RELOAD;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    pass_n  = 1'b0;
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = CHECK;
                end else begin
                    cnt_n = cnt - SW'(1);
                end
            end
            CHECK: begin
                if (abort) begin
                    // comparison on this cycle is dropped
                    pass_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_n = err_count + CNT_W'(1);
                        end
                        if (!seen) begin
                            seen_n = 1'b1;
                            fa_n   = A;
                            fb_n   = B;
                        end
                    end
                    if (last) begin
                        pass_n  = (err_n == '0);
                        state_n = DONE;
                    end else begin
                        b_n = B + WIDTH'(1);
                        if (&B) begin
                            a_n = A + WIDTH'(1);
                        end
                        cnt_n   = RELOAD;
                        state_n = WAIT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: small-width sweeps with injected adder faults,
// abort/restart, mid-run async reset, and per-vector settle timing.
module tb_adder_bist_ctrl;

    logic clk = 1'b0;
    logic rst, start, abort, start1, abort1;
    always #5 clk = ~clk;

    logic [3:0] A0, B0, sum0, fa0, fb0;
    logic       carry0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [1:0] A1, B1, sum1, fa1, fb1;
    logic       carry1, busy1, done1, pass1;
    logic [15:0] err1;

    int         mode;
    logic [4:0] flt [256];
    logic [4:0] g;
    int checks = 0;
    int errors = 0;

    // faulty adder seen by u0
    always_comb begin
        g = {1'b0, A0} + {1'b0, B0};
        case (mode)
            1: g[4] = 1'b0;
            2: g[0] = 1'b1;
            3: g[3] = 1'b0;
            4: g = g ^ flt[{A0, B0}];
            5: g[0] = ~g[0];
            default: ;
        endcase
    end
    assign sum0   = g[3:0];
    assign carry0 = g[4];
    assign {carry1, sum1} = {1'b0, A1} + {1'b0, B1};

    adder_bist_ctrl #(.WIDTH(4), .SETTLE(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .A(A0), .B(B0), .sum(sum0), .carry(carry0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_a(fa0), .fail_b(fb0)
    );

    adder_bist_ctrl #(.WIDTH(2), .SETTLE(3), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .A(A1), .B(B1), .sum(sum1), .carry(carry1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_a(fa1), .fail_b(fb1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // pulse start on u0 and run until done; optional extra start at step restart_at
    task automatic run0(input int restart_at, output int nb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int t = 0; t < 3000; t++) begin
            if (busy0) nb++;
            if (done0) break;
            start = (t == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_done", done0, 1);
    endtask

    typedef struct {
        int   mode;
        int   err;
        int   fa;
        int   fb;
        logic pass;
    } vec_t;

    vec_t tbl [5];
    int nb, j, n, e, fi, run, bad, nvec;
    logic [3:0] prev;

    initial begin
        tbl[0] = '{0, 0,   0, 0,  1'b1};
        tbl[1] = '{1, 120, 1, 15, 1'b0};
        tbl[2] = '{2, 128, 0, 0,  1'b0};
        tbl[3] = '{3, 128, 0, 8,  1'b0};
        tbl[4] = '{5, 255, 0, 0,  1'b0};
        for (int i = 0; i < 256; i++) flt[i] = '0;

        mode = 0; start = 0; abort = 0; start1 = 0; abort1 = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_u0", {A0, B0, fa0, fb0, err0, busy0, done0, pass0}, 0);
        chk("reset_u1", {A1, B1, fa1, fb1, err1, busy1, done1, pass1}, 0);
        rst = 1'b0;
        @(negedge clk);

        // fault table
        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            run0(-1, nb);
            chk($sformatf("busy_len_m%0d", mode), nb, 512);
            chk($sformatf("err_m%0d", mode), err0, tbl[i].err);
            chk($sformatf("fail_a_m%0d", mode), fa0, tbl[i].fa);
            chk($sformatf("fail_b_m%0d", mode), fb0, tbl[i].fb);
            chk($sformatf("pass_m%0d", mode), pass0, tbl[i].pass);
            chk($sformatf("busy_off_m%0d", mode), busy0, 0);
        end

        // random fault maps against a counting model
        for (int r = 0; r < 3; r++) begin
            e = 0; fi = -1;
            for (int i = 0; i < 256; i++) begin
                flt[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
                if (flt[i] != 0) begin
                    e++;
                    if (fi < 0) fi = i;
                end
            end
            if (fi < 0) fi = 0;
            if (e > 255) e = 255;
            mode = 4;
            run0(-1, nb);
            chk("rand_err", err0, e);
            chk("rand_fail_a", fa0, fi / 16);
            chk("rand_fail_b", fb0, fi % 16);
            chk("rand_pass", pass0, (e == 0));
        end

        // abort mid-run with sum[0] stuck-at-1
        mode = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = $urandom_range(20, 400);
        repeat (j - 1) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        n = (j - 1) / 2;
        e = 0;
        for (int k = 0; k < n; k++) if (((k / 16 + k % 16) % 2) == 0) e++;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_pass", pass0, 0);
        chk("abort_err", err0, e);
        chk("abort_a", A0, n / 16);
        chk("abort_b", B0, n % 16);
        repeat (3) @(negedge clk);
        chk("abort_idle", busy0, 0);

        // restart with an ignored start while busy
        mode = 0;
        run0(50, nb);
        chk("restart_busy_len", nb, 512);
        chk("restart_err", err0, 0);
        chk("restart_pass", pass0, 1);

        // async reset during CHECK
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        e = 0;
        for (int k = 0; k < 149; k++) if ((k / 16 + k % 16) >= 16) e++;
        chk("pre_rst_err", err0, e);
        chk("pre_rst_fail_a", fa0, 1);
        #2 rst = 1'b1;
        #1 chk("rst_mid", {A0, B0, fa0, fb0, err0, busy0, done0, pass0}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", {busy0, done0, A0, B0, err0}, 0);

        // SETTLE=3: each vector held exactly 4 cycles
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        nb = 0; run = 0; bad = 0; nvec = 0; prev = '1;
        for (int t = 0; t < 500; t++) begin
            if (done1) break;
            if (busy1) begin
                nb++;
                if ({A1, B1} != prev || run == 0) begin
                    if (run != 0 && run != 4) bad++;
                    run = 0;
                    nvec++;
                end
                prev = {A1, B1};
                run++;
            end
            @(negedge clk);
        end
        if (run != 4) bad++;
        chk("s3_done", done1, 1);
        chk("s3_busy_len", nb, 64);
        chk("s3_vectors", nvec, 16);
        chk("s3_bad_runs", bad, 0);
        chk("s3_pass", pass1, 1);
        chk("s3_err", err1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_bist_ctrl.md
# adder_bist_ctrl

Built-in self-test controller that drives the operand side of an 8-bit adder (e.g. `csa_8`) and checks its `sum`/`carry` response. It is the synthesizable counterpart of a directed adder bench. It sweeps all operand pairs exhaustively, waits a programmable settle time per pair, and compares the DUT result against an internal golden sum. It sits beside the adder under test and reports pass/fail, error count and the first failing vector.

## Interface
- `WIDTH`, 8: operand width; sweep covers 2^(2·WIDTH) pairs.
- `SETTLE`, 1: cycles between operand update and sample; must be ≥1.
- `CNT_W`, 16: width of the error counter.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin sweep; honoured only in IDLE or DONE.
- `abort` in 1: synchronous abort; returns to IDLE.
- `A` out WIDTH: operand A to DUT; registered.
- `B` out WIDTH: operand B to DUT; registered.
- `sum` in WIDTH: DUT sum.
- `carry` in 1: DUT carry-out.
- `busy` out 1: high in WAIT/CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: valid when `done`; 1 iff `err_count`==0.
- `err_count` out CNT_W: mismatches, saturating at all-ones.
- `fail_a`, `fail_b` out WIDTH: operands of the first mismatch; 0 if none.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- Reset (async, any state): state=IDLE. All outputs 0, including `A`, `B`, `err_count`, `fail_a`, `fail_b`, `busy`, `done` and `pass`. Settle counter=0.
- IDLE/DONE + `start`:
  - A=0, B=0, `err_count`=0.
  - `fail_*`=0, first-fail flag cleared.
  - `done`=0, `pass`=0.
  - Settle counter=SETTLE-1; go to WAIT.
- WAIT: if counter==0 go to CHECK, else decrement the counter.
- CHECK: compare {`carry`,`sum`} against the golden value A+B, computed at WIDTH+1 bits, zero-extended.
  - On mismatch: `err_count`+1, saturating.
  - On the first mismatch only: latch `fail_a`=A and `fail_b`=B.
  - Next state, last vector (A and B both all-ones): go to DONE; A/B hold their values.
  - Next state, otherwise: B+1. On B wrap to 0, also A+1. Reload the counter; go to WAIT.
- Sweep order: A outer loop, B inner loop, both ascending from 0.
- DONE: `done`=1, `pass`=(`err_count`==0). All results hold until `start` or reset.
- `abort` in WAIT/CHECK:
  - Go to IDLE next edge.
  - `done`=0, `pass`=0.
  - `err_count`/`fail_*` keep their partial values; A/B hold.
  - The CHECK comparison on an abort cycle is discarded.
- `abort` has priority over `start`. `start` in WAIT/CHECK is ignored.

## Timing
- A/B change only on the edge entering WAIT. The DUT is combinational and gets SETTLE+1 full cycles before sampling.
- Sample point: `sum`/`carry` are sampled at the rising edge that ends the CHECK cycle.
- Per vector: SETTLE+1 cycles. Total run = 2^(2·WIDTH)·(SETTLE+1) cycles, counted from the first WAIT cycle to the `done` rise.
  - WIDTH=8, SETTLE=1: 131072 cycles; `done` rises at edge 131073 after the `start` edge.
- `busy` deasserts on the same edge that `done` asserts.
- Result outputs (`err_count`, `fail_*`, `pass`) are registered and update on the CHECK exit edge.

## Test plan
- Correct behavioural adder, SETTLE=1, pulse `start`:
  - `busy` high for 131072 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_a`=`fail_b`=0.
- Adder with `carry` stuck-at-0:
  - `err_count`=32640, `pass`=0, `fail_a`=0x01, `fail_b`=0xFF.
- Adder with `sum[0]` stuck-at-1:
  - `err_count`=32768, `fail_a`=0x00, `fail_b`=0x00.
- SETTLE=3, correct adder, sampling check:
  - A/B stable for exactly 4 cycles per vector; run = 262144 cycles, `pass`=1.
- Abort and restart:
  - `abort` at cycle 1000 → IDLE next edge, `done`=0, `busy`=0.
  - `start` while busy → ignored.
  - Restart → full sweep with `err_count` cleared.
- Reset during CHECK:
  - `rst` pulse asynchronously clears every output to 0 mid-cycle; state=IDLE.
  - No further activity until `start`.
